// File: rtl/la_scanctrl.sv
// -----------------------------------------------------------------------------
// la_scanctrl
//
// Scan-chain controller. On a start request in IDLE it latches an N-bit
// pattern. It then shifts that pattern into a scan chain, least-significant
// bit first, over N cycles. While it shifts, it collects the previous chain
// contents from the chain tail. An optional single functional capture cycle
// can follow the shift. The run ends with a one-cycle done pulse.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   nreset    - asynchronous active-low reset
//   start     - run request, sampled only in IDLE
//   cap_en    - request one capture cycle after shifting (latched with start)
//   load_data - N-bit pattern to shift in (latched with start)
//   so        - scan-out from the chain tail flop (chain[0])
//   se        - scan enable to every flop in the chain
//   si        - scan-in to the chain head flop (chain[N-1])
//   result    - chain contents unloaded by the last completed shift,
//               bit i = old chain[i]
//   busy      - high in every state except IDLE
//   done      - single-cycle completion pulse
// -----------------------------------------------------------------------------
module la_scanctrl #(
    parameter int N    = 8,
    parameter     PROP = "DEFAULT"
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         start,
    input  logic         cap_en,
    input  logic [N-1:0] load_data,
    input  logic         so,
    output logic         se,
    output logic         si,
    output logic [N-1:0] result,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q,  state_d;
    logic [N-1:0]  shreg_q,  shreg_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic          cap_q,    cap_d;
    logic [N-1:0]  result_q, result_d;

    // The property string is carried for the integrator and not interpreted.
    logic unused_prop;
    assign unused_prop = (PROP == "DEFAULT");

    // Next shift-register value. The chain tail bit enters at the top. The
    // bit just presented on si drops out at the bottom. For N=1 the register
    // is replaced by so, because there is no upper slice to keep.
    logic [N-1:0] shift_next;
    generate
        if (N == 1) begin : g_shift_n1
            assign shift_next = so;
        end else begin : g_shift_nn
            assign shift_next = {so, shreg_q[N-1:1]};
        end
    endgenerate

    // NOTE: every variable gets a default before the case. Without these
    // defaults, a path that does not assign a variable would infer a latch.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = load_data;
                    cap_d   = cap_en;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = shift_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Final shift edge. The last chain bit arrives on so now,
                    // so capture the unloaded word from the shifted value.
                    result_d = shift_next;
                    cnt_d    = '0;
                    state_d  = cap_q ? ST_CAPTURE : ST_DONE;
                end
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then update together at the edge, independent of the order
    // of the statements.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            cap_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            result_q <= result_d;
        end
    end

    // Pin outputs decode from registered state and shreg_q[0] only, so they
    // cannot glitch. An asynchronous reset forces them low at once.
    assign se     = (state_q == ST_SHIFT);
    assign si     = (state_q == ST_SHIFT) & shreg_q[0];
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: doc/la_scanctrl.md
# la_scanctrl

Scan-chain controller that drives the scan-enable and scan-in pins of a chain of scan flops and collects the chain's scan-out. On a start request it serially loads an N-bit test pattern into the chain while unloading the previous chain contents. It then optionally pulses one functional capture cycle and reports the unloaded word. It sits directly upstream of the stdlib scan-flop chain and feeds the chain's `se` and `si` pins, with the chain tail `so` looped back.

## Interface
Parameters:
- N, 8, scan chain length in flops; must be >= 1.
- PROP, "DEFAULT", implementation property string, passed through and not interpreted.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- nreset, input, 1, reset; asynchronous assertion, active-low.
- start, input, 1, run request; sampled only in IDLE.
- cap_en, input, 1, request one capture cycle after shifting; latched with start.
- load_data, input, N, pattern to shift in; latched with start.
- so, input, 1, scan-out from the chain tail flop.
- se, output, 1, scan enable to every flop in the chain.
- si, output, 1, scan-in to the chain head flop.
- result, output, N, chain contents unloaded by the last completed shift.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, single-cycle completion pulse.

## Operation
- Chain model:
  - tail flop = chain[0], which drives `so`; head flop = chain[N-1], which is fed by `si`.
  - Each shift edge: chain[N-1] <= si, and chain[k] <= chain[k+1].
- States: IDLE, SHIFT, CAPTURE, DONE.
- IDLE:
  - se=0, si=0, busy=0.
  - If start=1 at an edge: shreg <= load_data, cap_q <= cap_en, cnt <= 0, go to SHIFT.
- SHIFT:
  - se=1 and si=shreg[0], both combinational from registered state.
  - Each edge: shreg <= {so, shreg[N-1:1]} and cnt <= cnt+1.
  - When cnt == N-1 at the edge: result <= {so, shreg[N-1:1]}, then go to CAPTURE if cap_q=1, else DONE.
- CAPTURE: se=0 and si=0 for exactly one cycle, so the chain flops load their functional d inputs; then go to DONE.
- DONE: done=1, se=0; next state IDLE unconditionally.
- After a completed run:
  - the chain holds load_data with bit i in chain[i], unless a capture followed;
  - result holds the pre-run chain with bit i = old chain[i].
- Counter width: $clog2(N+1); cnt never exceeds N-1.
- start outside IDLE is ignored, including during DONE. A start held high relaunches on the IDLE edge following DONE.
- load_data and cap_en changes after the launch edge have no effect on the current run.
- N=1: SHIFT lasts exactly one cycle.

## Timing
- Reset (nreset low), asynchronous, effective immediately:
  - state=IDLE, se=0, si=0, busy=0, done=0;
  - result=0, shreg=0, cnt=0, cap_q=0.
  - Reset during SHIFT or CAPTURE aborts the run with no done pulse; chain contents are then undefined.
- Deassertion of reset is treated as synchronous to clk by the integrator.
- Launch edge E (start=1 in IDLE):
  - SHIFT occupies cycles E+1 .. E+N, with se=1 throughout.
  - With cap_en=1: CAPTURE is cycle E+N+1 and done is high in cycle E+N+2.
  - With cap_en=0: done is high in cycle E+N+1.
- Back-to-back runs with start held high: the period is N+3 cycles with capture and N+2 without.
- result changes only on the final SHIFT edge and is stable from cycle E+N+1 until the next run's final shift.
- se, si, busy and done are glitch-free, decoded from registered state and shreg[0] only.

## Test plan
All scenarios use N=8 and a bench chain of 8 scan flops, with so = chain[0] and d inputs tied to a bench-controlled word.
- Reset: hold nreset low for 3 cycles with start=1 -> se=0, si=0, busy=0, done=0, result=0x00. Assert nreset mid-SHIFT (cycle E+3) -> se drops to 0 asynchronously, busy=0, no done pulse.
- Load: chain=0x00, start with load_data=0xA5, cap_en=0 -> se=1 for exactly 8 cycles, si sequence 1,0,1,0,0,1,0,1 (bit 0 first), done at E+9, result=0x00, chain=0xA5.
- Unload: from the previous state, start with load_data=0x0F, cap_en=0 -> result=0xA5, chain=0x0F.
- Capture: d=0x3C, start with load_data=0xFF, cap_en=1 -> se low for the single cycle E+9 and done at E+10. A following run with cap_en=0 -> result=0x3C.
- Start while busy: pulse start at E+4 with load_data=0x11 -> ignored; the current run completes with its original pattern, and busy stays high from E+1 to E+N+1 only.
- Held start, cap_en=1: done pulses every 11 cycles; N=1 build -> SHIFT lasts one cycle and done at E+3.
